code_change_logger: RTL and testbench

- Downstream consumer of the 3-bit priority/case code produced by the input-decode stage (OUT_IF / OUT_CASE style outputs).
- Samples the code every cycle and detects changes. Each change is logged as {code, timestamp} into a small show-ahead FIFO.
- A test/debug reader drains the FIFO with a valid/pop handshake. A sticky overflow flag records lost events.

---
 rtl/code_change_logger.sv | 117 +++++++++++
 tb/tb_code_change_logger.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_change_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | code_change_logger: logs {code, timestamp} on every change of IN_CODE    |
// | into a show-ahead FIFO with a valid/pop reader and sticky overflow.      |
// | Optional: CODE_LOG_ZERO_FILTER_EN suppresses logging of changes to 0.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module code_change_logger #(
  parameter int CODE_W  = 3,
  parameter int STAMP_W = 8,
  parameter int ADDR_W  = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CODE_W-1:0]   IN_CODE,
  input  logic                IN_POP,
  input  logic                IN_CLR_OVF,
  output logic                OUT_VALID,
  output logic [CODE_W-1:0]   OUT_CODE,
  output logic [STAMP_W-1:0]  OUT_STAMP,
  output logic [ADDR_W:0]     OUT_COUNT,
  output logic                OUT_OVF
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam int ENTRY_W = CODE_W + STAMP_W;
  localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

  logic [CODE_W-1:0]  prev_q,   prev_d;
  logic [STAMP_W-1:0] stamp_q,  stamp_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic change, log_req, pop, push, drop, empty, full;

  always_comb begin
    change = (IN_CODE != prev_q);
`ifdef CODE_LOG_ZERO_FILTER_EN
    log_req = change && (IN_CODE != '0);
`else
    log_req = change;
`endif
    empty = (count_q == '0);
    full  = (count_q == C_FULL);
    pop   = IN_POP && !empty;
    // A full FIFO can still accept a push when the head leaves on the same edge.
    push  = log_req && (!full || pop);
    drop  = log_req && full && !pop;
  end

  always_comb begin
    prev_d   = IN_CODE;
    stamp_d  = stamp_q + 1'b1;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (IN_CLR_OVF) begin
      ovf_d = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {IN_CODE, stamp_q};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q   <= '0;
      stamp_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      stamp_q  <= stamp_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: it is only observed through count_q.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    OUT_VALID = !empty;
    OUT_COUNT = count_q;
    OUT_OVF   = ovf_q;
    OUT_CODE  = '0;
    OUT_STAMP = '0;
    if (!empty) begin
      {OUT_CODE, OUT_STAMP} = mem_q[rd_ptr_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_change_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_code_change_logger: directed and randomized checks of the change      |
// | logger against a queue-based reference model.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_code_change_logger;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] IN_CODE = '0;
  logic       IN_POP = 1'b0;
  logic       IN_CLR_OVF = 1'b0;
  logic       OUT_VALID;
  logic [2:0] OUT_CODE;
  logic [7:0] OUT_STAMP;
  logic [2:0] OUT_COUNT;
  logic       OUT_OVF;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] stamp;
  } ent_t;

  ent_t m_q[$];
  int   m_stamp;
  int   m_prev;
  bit   m_ovf;

  code_change_logger dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_CODE    (IN_CODE),
    .IN_POP     (IN_POP),
    .IN_CLR_OVF (IN_CLR_OVF),
    .OUT_VALID  (OUT_VALID),
    .OUT_CODE   (OUT_CODE),
    .OUT_STAMP  (OUT_STAMP),
    .OUT_COUNT  (OUT_COUNT),
    .OUT_OVF    (OUT_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stamp = 0;
    m_prev  = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the logger, expressed as queue operations.
  task automatic model_step();
    bit do_log, popped, was_full;
    do_log = (int'(IN_CODE) != m_prev);
`ifdef CODE_LOG_ZERO_FILTER_EN
    if (IN_CODE == 0) do_log = 1'b0;
`endif
    was_full = (m_q.size() == 4);
    popped   = IN_POP && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (do_log && was_full && !popped) begin
      m_ovf = 1'b1;
    end else begin
      if (do_log) m_q.push_back('{IN_CODE, 8'(m_stamp)});
      if (IN_CLR_OVF) m_ovf = 1'b0;
    end
    m_prev  = IN_CODE;
    m_stamp = (m_stamp + 1) % 256;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, OUT_VALID, m_q.size() != 0);
    check({tag, ".count"}, OUT_COUNT, m_q.size());
    check({tag, ".ovf"},   OUT_OVF,   m_ovf);
    check({tag, ".code"},  OUT_CODE,  m_q.size() != 0 ? m_q[0].code  : 0);
    check({tag, ".stamp"}, OUT_STAMP, m_q.size() != 0 ? m_q[0].stamp : 0);
  endtask

  // Inputs are set at the falling edge before calling; outputs are compared at the next falling edge.
  task automatic step(input string tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all(tag);
  endtask

  task automatic drive(input int code, input bit pop, input bit clr);
    IN_CODE    = 3'(code);
    IN_POP     = pop;
    IN_CLR_OVF = clr;
  endtask

  task automatic sync_reset_start();
    drive(0, 0, 0);
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    model_reset();
    compare_all("rst");
    RST_N = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    drive(0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge CLK);

    // 1: idle after reset
    sync_reset_start();
    repeat (10) step("t1");
    drive(3, 0, 0);
    step("t1b");
    async_reset("t1_async");

    // 2: single change at stamp 5, then pop
    repeat (5) step("t2_idle");
    drive(1, 0, 0);
    step("t2_push");
    check("t2_code", OUT_CODE, 1);
    check("t2_stamp", OUT_STAMP, 5);
    drive(1, 1, 0);
    step("t2_pop");
    check("t2_empty", OUT_VALID, 0);
    drive(1, 0, 0);

    // 3: overflow on the fifth change
    sync_reset_start();
    repeat (10) step("t3_idle");
    foreach (m_q[i]) ;
    for (int i = 0; i < 5; i++) begin
      drive((i % 4) + 1, 0, 0);
      step("t3_fill");
    end
    check("t3_count", OUT_COUNT, 4);
    check("t3_ovf", OUT_OVF, 1);
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_code", OUT_CODE, i + 1);
      check("t3_drain_stamp", OUT_STAMP, 10 + i);
      drive(1, 1, 0);
      step("t3_drain");
    end
    drive(1, 0, 1);
    step("t3_clr");
    check("t3_ovf_clr", OUT_OVF, 0);

    // 4: full with simultaneous push and pop; pop on empty with push
    for (int i = 2; i <= 5; i++) begin
      drive(i, 0, 0);
      step("t4_fill");
    end
    drive(6, 1, 0);
    step("t4_pushpop");
    check("t4_count", OUT_COUNT, 4);
    check("t4_ovf", OUT_OVF, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("t4_last", OUT_CODE, 6);
      drive(6, 1, 0);
      step("t4_drain");
    end
    drive(7, 1, 0);
    step("t4_empty_pop");
    check("t4_count1", OUT_COUNT, 1);
    drive(7, 1, 0);
    step("t4_clean");

    // 5: stamp wrap, then zero-filter sequence
    sync_reset_start();
    drive(0, 0, 0);
    repeat (255) step("t5_idle");
    drive(1, 0, 0);
    step("t5_255");
    drive(2, 0, 0);
    step("t5_0");
    check("t5_stamp255", OUT_STAMP, 255);
    drive(2, 1, 0);
    step("t5_pop");
    check("t5_stamp0", OUT_STAMP, 0);
    drive(2, 1, 0);
    step("t5_drain");
    drive(6, 0, 0);
    step("t5_six");
    drive(6, 1, 0);
    step("t5_drain6");
    drive(2, 0, 0); step("t5_seq");
    drive(0, 0, 0); step("t5_seq");
    drive(3, 0, 0); step("t5_seq");
`ifdef CODE_LOG_ZERO_FILTER_EN
    check("t5_filter_count", OUT_COUNT, 2);
`else
    check("t5_filter_count", OUT_COUNT, 3);
`endif

    // 6: async reset with entries held, then stamp restarts
    async_reset("t6_async");
    repeat (3) step("t6_idle");
    drive(5, 0, 0);
    step("t6_push");
    check("t6_stamp", OUT_STAMP, 3);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : int'(IN_CODE),
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
      step("rnd");
      if ($urandom_range(0, 499) == 0) async_reset("rnd_async");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
